ctrl_pipe_unit: RTL
===================

Name: ctrl_pipe_unit

Overview:
- Parametrised, pipelined successor to the MIPS combinational control decoder.
- Decodes the ID-stage instruction and registers the control bundle plus register addresses into the ID/EX pipeline register.
- Adds load-use hazard detection with stall, branch-taken squash for a configurable number of cycles, downstream-stall hold, illegal-opcode detection and a saturating bubble counter.
- Sits between the IF/ID register and the EX stage.

Parameters:
- INST_W, 32: instruction width; opcode is [INST_W-1:INST_W-6], funct is [5:0].
- REG_A_W, 5: register address width; rs/rt/rd fields at MIPS positions.
- ALUC_W, 2: ALU control width; must be at least 2.
- FLUSH_CYCLES, 1: bubbles inserted after branch_taken; range 1..15.
- CNT_W, 16: bubble counter width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- instr_valid  in  1  instcode holds a real instruction.
- instcode  in  INST_W  ID-stage instruction.
- branch_taken  in  1  branch resolved taken this cycle.
- ex_stall  in  1  downstream stall; hold the ID/EX register.
- validE  out  1  ID/EX entry is a real instruction.
- regWriteE, regDstE, memWriteE, aluSrcE, memtoRegE, branchE  out  1 each  registered controls.
- ALUcontrolE  out  ALUC_W  registered ALU control.
- rsE, rtE, rdE  out  REG_A_W each  registered register fields.
- stall_f  out  1  combinational request to hold PC and IF/ID.
- flushing  out  1  FSM is in FLUSH.
- illegal_op  out  1  registered one-cycle pulse on undecodable valid instruction.
- bubble_cnt  out  CNT_W  saturating count of bubbles inserted.

Behaviour:
- Reset (async, rst_n=0):
  - All outputs 0; FSM=RUN; flush counter 0; bubble_cnt 0.
  - Takes effect immediately, including mid-flush.
- Decode table. Controls listed as regWrite, regDst, memWrite, aluSrc, memtoReg, branch, ALU. No X values; every don't-care is driven 0.
  - 100011 lw: 1,0,0,1,1,0,00.
  - 101011 sw: 0,0,1,1,0,0,00.
  - 000000 R-type: 1,1,0,0,0,0; funct 100000 gives ALU 00 (add), funct 100010 gives ALU 01 (sub), any other funct is illegal.
  - 001000 addi: 1,0,0,1,0,0,00.
  - 000100 beq: 0,0,0,0,0,1,10.
  - 000101 bne: 0,0,0,0,0,1,11.
  - Any other opcode with instr_valid=1 is illegal.
- Bubble:
  - validE=0 and every control output 0; rsE/rtE/rdE = 0.
  - bubble_cnt increments per bubble loaded and saturates at all-ones.
  - A hold does not count as a bubble.
- Load-use hazard (combinational):
  - Asserted when validE & memtoRegE & instr_valid & (rtE==rs or (uses_rt & rtE==rt)) & rtE!=0.
  - uses_rt is true for R-type, sw, beq, bne.
- stall_f = (hazard & FSM==RUN) | ex_stall.
- FSM RUN, per-edge priority (highest first):
  1. branch_taken: load bubble, go to FLUSH, counter=FLUSH_CYCLES-1.
  2. ex_stall: hold the ID/EX register unchanged.
  3. hazard: load bubble.
  4. illegal instruction: load bubble and pulse illegal_op.
  5. instr_valid: load decoded bundle with validE=1.
  6. Otherwise: load bubble.
- FSM FLUSH:
  - flushing=1; instcode ignored; bubble loaded every cycle, even under ex_stall.
  - branch_taken reloads the counter to FLUSH_CYCLES-1.
  - When the counter is 0, return to RUN at that edge; otherwise decrement.
  - Total bubbles per branch = FLUSH_CYCLES.
- Latency: decode-to-EX is 1 cycle.
- illegal_op is registered and held low otherwise.

Test Plan:
- Reset, then lw $8,4($1) (0x8C280004) valid -> next edge: validE=1, regWriteE=1, aluSrcE=1, memtoRegE=1, ALUcontrolE=00, rtE=8, bubble_cnt=0.
- lw $8 followed by add $9,$8,$2 (0x01024820) -> stall_f=1 for one cycle, one bubble (validE=0, bubble_cnt=1), then the add issues with regDstE=1, ALUcontrolE=00, rdE=9.
- sub $3,$4,$5 (0x00851822) -> ALUcontrolE=01; bne (opcode 000101) -> branchE=1, ALUcontrolE=11, regWriteE=0.
- FLUSH_CYCLES=2: branch_taken=1 for one cycle -> flushing=1 for 2 cycles, 2 bubbles, bubble_cnt +2, RUN resumes; branch_taken repeated mid-flush -> flush counter restarts.
- ex_stall=1 for 3 cycles with addi loaded -> ID/EX outputs unchanged, stall_f=1, bubble_cnt unchanged; opcode 111111 -> illegal_op pulses 1 cycle with a bubble.
- rst_n pulled low mid-FLUSH (asynchronously, between edges) -> all outputs 0 immediately, flushing=0, bubble_cnt=0; a valid instruction after release decodes normally.

Source files
------------

// File: rtl/ctrl_pipe_unit.sv
// ---------------------------------------------------------------------------
// ctrl_pipe_unit
// Pipelined MIPS control decoder. Decodes the ID-stage instruction and
// registers the control bundle and register fields into the ID/EX register.
// Also detects load-use hazards (stall request), squashes the wrong path
// after a taken branch, holds the ID/EX register under a downstream stall,
// flags illegal instructions and counts inserted bubbles (saturating).
//
// Ports
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   instr_valid         instcode carries a real instruction
//   instcode            ID-stage instruction
//   branch_taken        branch resolved taken this cycle
//   ex_stall            downstream stall, hold the ID/EX register
//   validE              ID/EX entry is a real instruction
//   regWriteE..branchE  registered control bits
//   ALUcontrolE         registered ALU control
//   rsE, rtE, rdE       registered register fields
//   stall_f             combinational request to hold PC and IF/ID
//   flushing            squashing the wrong path after a taken branch
//   illegal_op          one-cycle pulse for an undecodable valid instruction
//   bubble_cnt          saturating count of bubbles loaded into ID/EX
// ---------------------------------------------------------------------------
module ctrl_pipe_unit #(
   parameter int INST_W       = 32,
   parameter int REG_A_W      = 5,
   parameter int ALUC_W       = 2,
   parameter int FLUSH_CYCLES = 1,
   parameter int CNT_W        = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               instr_valid,
   input  logic [INST_W-1:0]  instcode,
   input  logic               branch_taken,
   input  logic               ex_stall,
   output logic               validE,
   output logic               regWriteE,
   output logic               regDstE,
   output logic               memWriteE,
   output logic               aluSrcE,
   output logic               memtoRegE,
   output logic               branchE,
   output logic [ALUC_W-1:0]  ALUcontrolE,
   output logic [REG_A_W-1:0] rsE,
   output logic [REG_A_W-1:0] rtE,
   output logic [REG_A_W-1:0] rdE,
   output logic               stall_f,
   output logic               flushing,
   output logic               illegal_op,
   output logic [CNT_W-1:0]   bubble_cnt
);

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] FN_ADD   = 6'b100000;
   localparam logic [5:0] FN_SUB   = 6'b100010;
   localparam logic [3:0] FCNT_INIT = 4'(FLUSH_CYCLES - 1);

   typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;
   typedef enum logic [1:0] {ACT_BUBBLE, ACT_LOAD, ACT_HOLD} act_t;

   state_t state, state_nxt;
   act_t   act;
   logic [3:0] fcnt, fcnt_nxt;
   logic   illegal_nxt;
   logic   run_rules;
   logic   hazard;

   // ---- stage p0: ID-stage decode ----
   logic [5:0]         op_p0, funct_p0;
   logic [REG_A_W-1:0] rs_p0, rt_p0, rd_p0;
   logic               rw_p0, rdst_p0, mw_p0, as_p0, mr_p0, br_p0;
   logic [1:0]         alu_p0;
   logic               legal_p0, uses_rt_p0;
   logic               unused_bits;

   assign op_p0       = instcode[INST_W-1 -: 6];
   assign funct_p0    = instcode[5:0];
   assign rs_p0       = instcode[21 +: REG_A_W];
   assign rt_p0       = instcode[16 +: REG_A_W];
   assign rd_p0       = instcode[11 +: REG_A_W];
   assign unused_bits = ^instcode;

   always_comb begin
      rw_p0      = 1'b0;
      rdst_p0    = 1'b0;
      mw_p0      = 1'b0;
      as_p0      = 1'b0;
      mr_p0      = 1'b0;
      br_p0      = 1'b0;
      alu_p0     = 2'b00;
      legal_p0   = 1'b0;
      uses_rt_p0 = 1'b0;
      case (op_p0)
         OP_LW: begin
            rw_p0 = 1'b1; as_p0 = 1'b1; mr_p0 = 1'b1; legal_p0 = 1'b1;
         end
         OP_SW: begin
            mw_p0 = 1'b1; as_p0 = 1'b1; legal_p0 = 1'b1; uses_rt_p0 = 1'b1;
         end
         OP_RTYPE: begin
            uses_rt_p0 = 1'b1;
            if (funct_p0 == FN_ADD) begin
               rw_p0 = 1'b1; rdst_p0 = 1'b1; legal_p0 = 1'b1;
            end else if (funct_p0 == FN_SUB) begin
               rw_p0 = 1'b1; rdst_p0 = 1'b1; alu_p0 = 2'b01; legal_p0 = 1'b1;
            end
         end
         OP_ADDI: begin
            rw_p0 = 1'b1; as_p0 = 1'b1; legal_p0 = 1'b1;
         end
         OP_BEQ: begin
            br_p0 = 1'b1; alu_p0 = 2'b10; legal_p0 = 1'b1; uses_rt_p0 = 1'b1;
         end
         OP_BNE: begin
            br_p0 = 1'b1; alu_p0 = 2'b11; legal_p0 = 1'b1; uses_rt_p0 = 1'b1;
         end
         default: ;
      endcase
   end

   // A load in EX whose destination feeds the ID instruction must be
   // separated by one bubble. $0 never creates a dependency.
   assign hazard = validE & memtoRegE & instr_valid
                 & ((rtE == rs_p0) | (uses_rt_p0 & (rtE == rt_p0)))
                 & (rtE != '0);

   assign stall_f  = (hazard & (state == RUN)) | ex_stall;
   assign flushing = (state == FLUSH);

   // Action selection. The last FLUSH cycle (counter at 0) already holds
   // the branch target in ID, so that edge is resolved with the RUN rules;
   // this makes the squash exactly FLUSH_CYCLES bubbles long.
   always_comb begin
      state_nxt   = state;
      fcnt_nxt    = fcnt;
      act         = ACT_BUBBLE;
      illegal_nxt = 1'b0;
      run_rules   = 1'b0;
      case (state)
         RUN: run_rules = 1'b1;
         FLUSH: begin
            if (branch_taken) begin
               fcnt_nxt = FCNT_INIT;
            end else if (fcnt == 4'd0) begin
               state_nxt = RUN;
               run_rules = 1'b1;
            end else begin
               fcnt_nxt = fcnt - 4'd1;
            end
         end
         default: ;
      endcase
      if (run_rules) begin
         if (branch_taken) begin
            state_nxt = FLUSH;
            fcnt_nxt  = FCNT_INIT;
         end else if (ex_stall) begin
            act = ACT_HOLD;
         end else if (hazard) begin
            act = ACT_BUBBLE;
         end else if (instr_valid && !legal_p0) begin
            illegal_nxt = 1'b1;
         end else if (instr_valid) begin
            act = ACT_LOAD;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= RUN;
         fcnt  <= 4'd0;
      end else begin
         state <= state_nxt;
         fcnt  <= fcnt_nxt;
      end
   end

   // ---- stage p1: ID/EX register ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         validE      <= 1'b0;
         regWriteE   <= 1'b0;
         regDstE     <= 1'b0;
         memWriteE   <= 1'b0;
         aluSrcE     <= 1'b0;
         memtoRegE   <= 1'b0;
         branchE     <= 1'b0;
         ALUcontrolE <= '0;
         rsE         <= '0;
         rtE         <= '0;
         rdE         <= '0;
         illegal_op  <= 1'b0;
         bubble_cnt  <= '0;
      end else begin
         illegal_op <= illegal_nxt;
         case (act)
            ACT_LOAD: begin
               validE      <= 1'b1;
               regWriteE   <= rw_p0;
               regDstE     <= rdst_p0;
               memWriteE   <= mw_p0;
               aluSrcE     <= as_p0;
               memtoRegE   <= mr_p0;
               branchE     <= br_p0;
               ALUcontrolE <= ALUC_W'(alu_p0);
               rsE         <= rs_p0;
               rtE         <= rt_p0;
               rdE         <= rd_p0;
            end
            ACT_BUBBLE: begin
               validE      <= 1'b0;
               regWriteE   <= 1'b0;
               regDstE     <= 1'b0;
               memWriteE   <= 1'b0;
               aluSrcE     <= 1'b0;
               memtoRegE   <= 1'b0;
               branchE     <= 1'b0;
               ALUcontrolE <= '0;
               rsE         <= '0;
               rtE         <= '0;
               rdE         <= '0;
               if (bubble_cnt != '1)
                  bubble_cnt <= bubble_cnt + CNT_W'(1);
            end
            default: ;
         endcase
      end
   end

endmodule
